adc_capture_seq: RTL and testbench

ADC_CAPTURE_SEQ -- requirements
Module: adc_capture_seq

---
 rtl/adc_capture_seq.sv | 149 ++++++++++++++
 tb/tb_adc_capture_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_seq.sv
// adc_capture_seq: applies a calibrator selection, waits for it to settle, then captures a burst of
// ADC samples into the offs/meas RAM B-port. Define ADC_CAPTURE_TIMEOUT_EN to enable the sample-gap timeout.
module adc_capture_seq #(
    parameter int unsigned g_settle_cycles  = 256,
    parameter int unsigned g_timeout_cycles = 65535
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        mode_i,
    input  logic [1:0]  cal_sel_i,
    input  logic [11:0] nsamples_i,
    input  logic        adc_valid_i,
    input  logic [31:0] adc_data_i,
    output logic [1:0]  cal_sel_o,
    output logic [11:0] ram_adr_o,
    output logic [31:0] ram_dat_o,
    output logic        offs_we_o,
    output logic        meas_we_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [12:0] count_o,
    output logic        timeout_o,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int unsigned SETTLE_EFF  = (g_settle_cycles == 0) ? 1 : g_settle_cycles;
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_EFF - 1);

    state_t      state_q, state_d;
    logic        mode_q;
    logic [11:0] nsamples_q;
    logic [11:0] adr_q;
    logic [31:0] settle_cnt;
    logic        sample_take;

`ifdef ADC_CAPTURE_TIMEOUT_EN
    localparam int unsigned TMO_EFF  = (g_timeout_cycles == 0) ? 1 : g_timeout_cycles;
    localparam logic [31:0] GAP_LAST = 32'(TMO_EFF - 1);
    logic [31:0] gap_cnt;
    logic        timeout_hit;
`endif

    // ADC stream is valid-only (no ready): a sample is consumed in every CAPTURE cycle with
    // adc_valid_i high and abort_i low, and its RAM write is issued on the following cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        sample_take = 1'b0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) state_d = SETTLE;
            end
            SETTLE: begin
                if (abort_i)                        state_d = IDLE;
                else if (settle_cnt == SETTLE_LAST) state_d = CAPTURE;
            end
            CAPTURE: begin
                // abort wins over a sample arriving in the same cycle, including the last one
                if (abort_i) begin
                    state_d = IDLE;
                end else if (adc_valid_i) begin
                    sample_take = 1'b1;
                    if (adr_q == nsamples_q) state_d = DONE;
                end
`ifdef ADC_CAPTURE_TIMEOUT_EN
                else if (gap_cnt == GAP_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_q     <= 1'b0;
            nsamples_q <= '0;
            adr_q      <= '0;
            settle_cnt <= '0;
            cal_sel_o  <= '0;
            ram_adr_o  <= '0;
            ram_dat_o  <= '0;
            offs_we_o  <= 1'b0;
            meas_we_o  <= 1'b0;
            count_o    <= '0;
        end else begin
            offs_we_o <= 1'b0;
            meas_we_o <= 1'b0;
            if (state_q == IDLE && start_i) begin
                mode_q     <= mode_i;
                nsamples_q <= nsamples_i;
                cal_sel_o  <= cal_sel_i;
                count_o    <= '0;
                settle_cnt <= '0;
                adr_q      <= '0;
            end
            if (state_q == SETTLE) settle_cnt <= settle_cnt + 32'd1;
            if (state_q == SETTLE && state_d == CAPTURE) adr_q <= '0;
            if (sample_take) begin
                ram_adr_o <= adr_q;
                ram_dat_o <= adc_data_i;
                offs_we_o <= ~mode_q;
                meas_we_o <= mode_q;
                adr_q     <= adr_q + 12'd1;
                count_o   <= count_o + 13'd1;
            end
        end
    end

`ifdef ADC_CAPTURE_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gap_cnt   <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (state_q == SETTLE && state_d == CAPTURE) gap_cnt <= '0;
            else if (state_q == CAPTURE)                 gap_cnt <= sample_take ? 32'd0 : gap_cnt + 32'd1;
            // sticky until the next accepted start
            if (state_q == IDLE && start_i) timeout_o <= 1'b0;
            else if (timeout_hit)           timeout_o <= 1'b1;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

    assign busy_o  = (state_q == SETTLE) || (state_q == CAPTURE);
    assign done_o  = (state_q == DONE);
    assign state_o = state_q;

endmodule

// File: tb/tb_adc_capture_seq.sv
// Testbench for adc_capture_seq: randomized capture bursts checked against a per-sample write
// scoreboard derived from the capture rules (settle length, sample count, abort, gap timeout).
`timescale 1ns/1ps
module tb_adc_capture_seq;
    localparam int S   = 4;
    localparam int TMO = 8;
    localparam int W   = 46;
`ifdef ADC_CAPTURE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk_i, rst_n_i, start_i, abort_i, mode_i, adc_valid_i;
    logic [1:0]  cal_sel_i;
    logic [11:0] nsamples_i;
    logic [31:0] adc_data_i;
    logic [1:0]  cal_sel_o, state_o;
    logic [11:0] ram_adr_o;
    logic [31:0] ram_dat_o;
    logic        offs_we_o, meas_we_o, busy_o, done_o, timeout_o;
    logic [12:0] count_o;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    adc_capture_seq #(.g_settle_cycles(S), .g_timeout_cycles(TMO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
        .mode_i(mode_i), .cal_sel_i(cal_sel_i), .nsamples_i(nsamples_i),
        .adc_valid_i(adc_valid_i), .adc_data_i(adc_data_i), .cal_sel_o(cal_sel_o),
        .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o), .offs_we_o(offs_we_o),
        .meas_we_o(meas_we_o), .busy_o(busy_o), .done_o(done_o), .count_o(count_o),
        .timeout_o(timeout_o), .state_o(state_o)
    );

    function automatic void check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endfunction

    // scoreboard: every RAM write must match the oldest expected {meas,offs,adr,data}
    always @(negedge clk_i) begin
        if (offs_we_o || meas_we_o) begin
            if (exp_q.size() == 0) check("unexp_wr", 64'({meas_we_o, offs_we_o}), 64'd0);
            else                   check("wr", 64'({meas_we_o, offs_we_o, ram_adr_o, ram_dat_o}), 64'(exp_q.pop_front()));
        end
    end

    task automatic drive_noise();
        start_i    = 1'($urandom_range(0, 1));
        mode_i     = 1'($urandom_range(0, 1));
        cal_sel_i  = 2'($urandom_range(0, 3));
        nsamples_i = 12'($urandom_range(0, 4095));
    endtask

    // vpat: 0 valid every cycle, 1 toggling, 2 random (~3/4); abort_k/stop_k < 0 disables
    task automatic run_capture(input logic m, input logic [1:0] cal, input logic [11:0] ns,
                               input int vpat, input int abort_k, input int stop_k, input bit noise);
        int k, cyc, idle;
        bit fin, v, aborted, timed_out;
        k = 0; cyc = 0; idle = 0; fin = 0; aborted = 0; timed_out = 0;
        start_i = 1'b1; mode_i = m; cal_sel_i = cal; nsamples_i = ns;
        adc_valid_i = 1'b0; abort_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        check("cal_sel_applied", 64'(cal_sel_o), 64'(cal));
        check("count_clr", 64'(count_o), 64'd0);
        check("timeout_clr", 64'(timeout_o), 64'd0);
        for (int i = 0; i < S; i++) begin
            check("busy_settle", 64'(busy_o), 64'd1);
            adc_valid_i = (i == S - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            adc_data_i  = $urandom;
            if (noise) drive_noise();
            @(negedge clk_i);
        end
        while (!fin && cyc < 20000) begin
            check("busy_cap", 64'(busy_o), 64'd1);
            check("done_cap", 64'(done_o), 64'd0);
            case (vpat)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            if (stop_k >= 0 && k >= stop_k) v = 1'b0;
            adc_valid_i = v;
            adc_data_i  = $urandom;
            abort_i     = 1'b0;
            if (noise) drive_noise();
            if (v) begin
                idle = 0;
                if (k == abort_k) begin
                    abort_i = 1'b1; aborted = 1'b1; fin = 1'b1;
                end else begin
                    exp_q.push_back({m, ~m, 12'(k), adc_data_i});
                    if (k == int'(ns)) fin = 1'b1;
                    k++;
                end
            end else begin
                idle++;
                if (TMO_EN && idle == TMO) begin timed_out = 1'b1; fin = 1'b1; end
            end
            @(negedge clk_i);
            cyc++;
        end
        adc_valid_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
        check("cap_bound", 64'(cyc >= 20000), 64'd0);
        check("done_pulse", 64'(done_o), 64'(!aborted && !timed_out));
        check("busy_end", 64'(busy_o), 64'd0);
        check("count_end", 64'(count_o), 64'(k));
        check("timeout_flag", 64'(timeout_o), 64'(timed_out));
        @(negedge clk_i);
        check("done_one_cycle", 64'(done_o), 64'd0);
        check("cal_sel_hold", 64'(cal_sel_o), 64'(cal));
        check("timeout_sticky", 64'(timeout_o), 64'(timed_out));
        repeat (3) begin
            adc_valid_i = 1'($urandom_range(0, 1));
            adc_data_i  = $urandom;
            @(negedge clk_i);
        end
        adc_valid_i = 1'b0;
        check("wr_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 64'({cal_sel_o, ram_adr_o, ram_dat_o, offs_we_o, meas_we_o,
                        busy_o, done_o, count_o, timeout_o}), 64'd0);
    endtask

    task automatic reset_mid_capture();
        start_i = 1'b1; mode_i = 1'b1; cal_sel_i = 2'b01; nsamples_i = 12'd20;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (S) @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            adc_valid_i = 1'b1;
            adc_data_i  = $urandom | 32'h1;
            exp_q.push_back({2'b10, 12'(i), adc_data_i});
            @(negedge clk_i);
        end
        adc_valid_i = 1'b1;
        adc_data_i  = $urandom;
        #2 rst_n_i = 1'b0;
        #1 check_all_zero("rst_async_zero");
        @(negedge clk_i);
        check_all_zero("rst_hold_zero");
        rst_n_i = 1'b1;
        repeat (5) begin
            adc_valid_i = 1'b1;
            adc_data_i  = $urandom;
            @(negedge clk_i);
        end
        adc_valid_i = 1'b0;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0;
        cal_sel_i = 2'b00; nsamples_i = 12'd0; adc_valid_i = 1'b0; adc_data_i = 32'd0;
        repeat (2) @(negedge clk_i);
        check_all_zero("reset_state");
        rst_n_i = 1'b1;
        @(negedge clk_i);

        run_capture(1'b1, 2'b10, 12'd3, 0, -1, -1, 1'b0);
        run_capture(1'b0, 2'($urandom_range(0, 3)), 12'd15, 1, -1, -1, 1'b0);
        run_capture(1'b1, 2'b01, 12'd10, 0, 2, -1, 1'b0);
        run_capture(1'b0, 2'b11, 12'd5, 0, -1, -1, 1'b0);
        run_capture(1'b0, 2'b11, 12'd12, 2, -1, -1, 1'b1);
        reset_mid_capture();
        run_capture(1'b1, 2'b10, 12'd2, 0, -1, -1, 1'b0);
        run_capture(1'($urandom_range(0, 1)), 2'b11, 12'd4095, 0, -1, -1, 1'b0);
`ifdef ADC_CAPTURE_TIMEOUT_EN
        run_capture(1'b1, 2'b01, 12'd20, 0, -1, 2, 1'b0);
`endif
        for (int r = 0; r < 4; r++)
            run_capture(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        12'($urandom_range(0, 40)), 2, -1, -1, 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
